// File: rtl/bpu_pkg.sv
// Shared types and helpers for the bimodal/gshare branch prediction unit.
package bpu_pkg;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_state_e;

    // Two-bit saturating step: taken moves toward ST, not-taken toward SNT.
    function automatic logic [1:0] sat_update(input logic [1:0] state, input logic taken);
        logic [1:0] w_next;
        if (taken)
            w_next = (state == ST) ? state : state + 2'd1;
        else
            w_next = (state == SNT) ? state : state - 2'd1;
        return w_next;
    endfunction

endpackage

// File: rtl/bpu_sat_counter.sv
// One 2-bit saturating direction counter with async reset and update enable.
module bpu_sat_counter
    import bpu_pkg::*;
#(
    parameter logic [1:0] INIT_STATE = 2'b01
) (
    input  logic       in_clk,
    input  logic       in_rst,
    input  logic       in_en,
    input  logic       in_taken,
    output logic [1:0] out_state
);

    logic [1:0] r_state;

    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst)
            r_state <= INIT_STATE;
        else if (in_en)
            r_state <= sat_update(r_state, in_taken);
    end

    assign out_state = r_state;

endmodule

// File: rtl/branch_prediction_unit.sv
// Bimodal branch direction predictor with saturating mispredict counter.
// Define BPU_GSHARE_EN to xor a global history register into the lookup index.
module branch_prediction_unit
    import bpu_pkg::*;
#(
    parameter int         PC_W       = 64,
    parameter int         IDX_W      = 6,
    parameter int         CNT_W      = 32,
    parameter logic [1:0] INIT_STATE = 2'b01
) (
    input  logic             in_clk,
    input  logic             in_rst,
    input  logic             in_lookup_valid,
    input  logic [PC_W-1:0]  in_pc,
    output logic             out_prediction,
    output logic [IDX_W-1:0] out_pred_idx,
    input  logic             in_update_valid,
    input  logic [IDX_W-1:0] in_update_idx,
    input  logic             in_update_taken,
    input  logic             in_update_predicted,
    output logic [CNT_W-1:0] out_mispredict_cnt
);

    localparam int NUM_ENT = 1 << IDX_W;

    logic [NUM_ENT-1:0][1:0] w_states;
    logic [NUM_ENT-1:0]      w_upd_en;
    logic [IDX_W-1:0]        w_pc_idx;
    logic [IDX_W-1:0]        w_idx;
    logic [1:0]              w_rd_state;
    logic                    w_mispredict;
    logic [CNT_W-1:0]        r_mis_cnt;

    generate
        for (genvar g = 0; g < NUM_ENT; g++) begin : g_ent
            assign w_upd_en[g] = in_update_valid && (in_update_idx == IDX_W'(g));

            bpu_sat_counter #(
                .INIT_STATE (INIT_STATE)
            ) u_ctr (
                .in_clk    (in_clk),
                .in_rst    (in_rst),
                .in_en     (w_upd_en[g]),
                .in_taken  (in_update_taken),
                .out_state (w_states[g])
            );
        end
    endgenerate

    // Word-aligned fetch: the two low PC bits carry no index information.
    assign w_pc_idx = in_pc[IDX_W+1:2];

`ifdef BPU_GSHARE_EN
    logic [IDX_W-1:0] r_ghr;

    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst)
            r_ghr <= '0;
        else if (in_update_valid)
            r_ghr <= {r_ghr[IDX_W-2:0], in_update_taken};
    end

    assign w_idx = w_pc_idx ^ r_ghr;
`else
    assign w_idx = w_pc_idx;
`endif

    // Reads the registered table, so a same-cycle update is seen one cycle later.
    assign w_rd_state     = w_states[w_idx];
    assign out_prediction = in_lookup_valid & w_rd_state[1];
    assign out_pred_idx   = w_idx;

    assign w_mispredict = in_update_valid && (in_update_taken != in_update_predicted);

    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst)
            r_mis_cnt <= '0;
        else if (w_mispredict && (r_mis_cnt != {CNT_W{1'b1}}))
            r_mis_cnt <= r_mis_cnt + CNT_W'(1);
    end

    assign out_mispredict_cnt = r_mis_cnt;

    logic w_unused;
    assign w_unused = ^{in_pc[PC_W-1:IDX_W+2], in_pc[1:0], w_rd_state[0]};

endmodule

// File: tb/tb_branch_prediction_unit.sv
// Scoreboard bench for branch_prediction_unit: stimulus pushes expectations, a monitor checks them.
module tb_branch_prediction_unit;

    logic        clk = 1'b0;
    logic        in_rst = 1'b1;
    logic        in_lookup_valid = 1'b0;
    logic [63:0] in_pc = '0;
    logic        in_update_valid = 1'b0;
    logic [5:0]  in_update_idx = '0;
    logic        in_update_taken = 1'b0;
    logic        in_update_predicted = 1'b0;

    logic        out_prediction, out_prediction4;
    logic [5:0]  out_pred_idx, out_pred_idx4;
    logic [31:0] out_mispredict_cnt;
    logic [3:0]  out_mispredict_cnt4;

    always #5 clk = ~clk;

    branch_prediction_unit dut (
        .in_clk              (clk),
        .in_rst              (in_rst),
        .in_lookup_valid     (in_lookup_valid),
        .in_pc               (in_pc),
        .out_prediction      (out_prediction),
        .out_pred_idx        (out_pred_idx),
        .in_update_valid     (in_update_valid),
        .in_update_idx       (in_update_idx),
        .in_update_taken     (in_update_taken),
        .in_update_predicted (in_update_predicted),
        .out_mispredict_cnt  (out_mispredict_cnt)
    );

    branch_prediction_unit #(.CNT_W(4)) dut4 (
        .in_clk              (clk),
        .in_rst              (in_rst),
        .in_lookup_valid     (in_lookup_valid),
        .in_pc               (in_pc),
        .out_prediction      (out_prediction4),
        .out_pred_idx        (out_pred_idx4),
        .in_update_valid     (in_update_valid),
        .in_update_idx       (in_update_idx),
        .in_update_taken     (in_update_taken),
        .in_update_predicted (in_update_predicted),
        .out_mispredict_cnt  (out_mispredict_cnt4)
    );

    typedef struct {
        string       nm;
        logic        pred;
        logic [5:0]  idx;
        logic [31:0] cnt;
        logic [3:0]  cnt4;
    } exp_t;

    exp_t q[$];
    exp_t m_e;
    logic mon_en = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    // Monitor: sample mid-cycle whenever the stimulus flagged a checked cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (q.size() == 0) begin
                    miscompares++;
                    $display("FAIL scoreboard_empty: output presented with no expectation queued");
                end else begin
                    m_e = q.pop_front();
                    vectors++;
                    if (out_prediction !== m_e.pred || out_pred_idx !== m_e.idx ||
                        out_mispredict_cnt !== m_e.cnt || out_prediction4 !== m_e.pred ||
                        out_pred_idx4 !== m_e.idx || out_mispredict_cnt4 !== m_e.cnt4) begin
                        miscompares++;
                        $display("FAIL %s: got pred=%0b idx=%0d cnt=%0d cnt4=%0d (pred4=%0b idx4=%0d), want pred=%0b idx=%0d cnt=%0d cnt4=%0d",
                                 m_e.nm, out_prediction, out_pred_idx, out_mispredict_cnt,
                                 out_mispredict_cnt4, out_prediction4, out_pred_idx4,
                                 m_e.pred, m_e.idx, m_e.cnt, m_e.cnt4);
                    end
                end
            end
        end
    end

    task automatic drv(input logic lv, input logic [63:0] pc, input logic uv,
                       input logic [5:0] ui, input logic ut, input logic up);
        @(posedge clk);
        #1;
        mon_en              = 1'b0;
        in_lookup_valid     = lv;
        in_pc               = pc;
        in_update_valid     = uv;
        in_update_idx       = ui;
        in_update_taken     = ut;
        in_update_predicted = up;
    endtask

    task automatic lk(input logic [63:0] pc);
        drv(1'b1, pc, 1'b0, 6'd0, 1'b0, 1'b0);
    endtask

    task automatic upd(input logic [5:0] ui, input logic ut, input logic up);
        drv(1'b0, 64'h0, 1'b1, ui, ut, up);
    endtask

    task automatic expect_v(input string nm, input logic pred, input logic [5:0] idx,
                            input logic [31:0] cnt, input logic [3:0] cnt4);
        exp_t e;
        e.nm   = nm;
        e.pred = pred;
        e.idx  = idx;
        e.cnt  = cnt;
        e.cnt4 = cnt4;
        q.push_back(e);
        mon_en = 1'b1;
    endtask

    initial begin
        // Reset state, checked while reset is still held.
        lk(64'h1000);
        expect_v("reset_lookup", 1'b0, 6'd0, 32'd0, 4'd0);
        lk(64'h1000);
        in_rst = 1'b0;
        expect_v("post_reset_lookup", 1'b0, 6'd0, 32'd0, 4'd0);

`ifdef BPU_GSHARE_EN
        upd(6'd0, 1'b1, 1'b1);
        upd(6'd0, 1'b1, 1'b1);
        upd(6'd0, 1'b0, 1'b0);
        lk(64'h0);
        expect_v("gshare_pc0", 1'b0, 6'd6, 32'd0, 4'd0);
        lk(64'h18);
        expect_v("gshare_pc18", 1'b1, 6'd0, 32'd0, 4'd0);
`else
        drv(1'b0, 64'h14, 1'b0, 6'd0, 1'b0, 1'b0);
        expect_v("no_valid_idx5", 1'b0, 6'd5, 32'd0, 4'd0);

        // Train idx 5 up to strongly taken and back down.
        for (int i = 0; i < 3; i++) upd(6'd5, 1'b1, 1'b1);
        lk(64'h14);
        expect_v("idx5_st", 1'b1, 6'd5, 32'd0, 4'd0);
        upd(6'd5, 1'b0, 1'b0);
        lk(64'h14);
        expect_v("idx5_wt", 1'b1, 6'd5, 32'd0, 4'd0);
        upd(6'd5, 1'b0, 1'b0);
        lk(64'h14);
        expect_v("idx5_wnt", 1'b0, 6'd5, 32'd0, 4'd0);

        // Underflow must saturate at 00, not wrap.
        for (int i = 0; i < 2; i++) upd(6'd0, 1'b0, 1'b0);
        lk(64'h0);
        expect_v("idx0_snt_nowrap", 1'b0, 6'd0, 32'd0, 4'd0);
        for (int i = 0; i < 3; i++) upd(6'd0, 1'b0, 1'b0);
        upd(6'd0, 1'b1, 1'b1);
        lk(64'h0);
        expect_v("idx0_back_to_wnt", 1'b0, 6'd0, 32'd0, 4'd0);
        upd(6'd0, 1'b1, 1'b1);
        lk(64'h0);
        expect_v("idx0_wt", 1'b1, 6'd0, 32'd0, 4'd0);

        // Same-cycle update and lookup: no bypass.
        drv(1'b1, 64'h24, 1'b1, 6'd9, 1'b1, 1'b1);
        expect_v("idx9_same_cycle", 1'b0, 6'd9, 32'd0, 4'd0);
        lk(64'h24);
        expect_v("idx9_next_cycle", 1'b1, 6'd9, 32'd0, 4'd0);
        lk(64'h28);
        expect_v("idx10_untouched", 1'b0, 6'd10, 32'd0, 4'd0);

        // Mispredict counting, three of five mismatched.
        upd(6'd20, 1'b1, 1'b0);
        upd(6'd20, 1'b0, 1'b0);
        upd(6'd20, 1'b0, 1'b1);
        upd(6'd20, 1'b1, 1'b1);
        upd(6'd20, 1'b1, 1'b0);
        lk(64'h50);
        expect_v("mis_cnt3", 1'b1, 6'd20, 32'd3, 4'd3);

        // Narrow counter saturates at 15 while the wide one keeps counting.
        for (int i = 0; i < 12; i++) upd(6'd30, 1'b1, 1'b0);
        drv(1'b0, 64'h78, 1'b0, 6'd0, 1'b0, 1'b0);
        expect_v("mis_cnt15", 1'b0, 6'd30, 32'd15, 4'd15);
        for (int i = 0; i < 8; i++) upd(6'd30, 1'b1, 1'b0);
        lk(64'h78);
        expect_v("mis_cnt_sat", 1'b1, 6'd30, 32'd23, 4'd15);

        // Asynchronous reset mid-cycle, then an update on the first edge after release.
        lk(64'h78);
        in_rst = 1'b1;
        expect_v("rst_mid_run", 1'b0, 6'd30, 32'd0, 4'd0);
        drv(1'b1, 64'h78, 1'b1, 6'd30, 1'b1, 1'b1);
        in_rst = 1'b0;
        expect_v("rst_release_wnt", 1'b0, 6'd30, 32'd0, 4'd0);
        lk(64'h78);
        expect_v("first_edge_update", 1'b1, 6'd30, 32'd0, 4'd0);
        lk(64'h0);
        expect_v("idx0_reset_to_wnt", 1'b0, 6'd0, 32'd0, 4'd0);
`endif

        @(posedge clk);
        #1;
        mon_en = 1'b0;
        @(negedge clk);
        #1;
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: %0d expectations left, want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
